// File: rtl/acc_pkg.sv
// =====================================================================
// Package     : acc_pkg
// Description : Shared types and widths for the adaptive-cruise
//               supervisory logic, plus the throttle ramp helper.
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

package acc_pkg;

  localparam int ACC_STATE_W = 3;
  localparam int ACC_ACT_W   = 8;
  localparam int ACC_SPEED_W = 16;

  typedef enum logic [ACC_STATE_W-1:0] {
    ACC_OFF      = 3'd0,
    ACC_STANDBY  = 3'd1,
    ACC_ACTIVE   = 3'd2,
    ACC_OVERRIDE = 3'd3,
    ACC_FAULT    = 3'd4
  } acc_state_e;

  // One ramp step: rise by at most 'step', fall straight to the target.
  // The sum is kept in 9 bits so cur+step never wraps near full scale.
  function automatic logic [ACC_ACT_W-1:0] acc_ramp(
    input logic [ACC_ACT_W-1:0] cur,
    input logic [ACC_ACT_W-1:0] tgt,
    input logic [ACC_ACT_W:0]   step
  );
    logic [ACC_ACT_W:0] w_limit;
    w_limit = {1'b0, cur} + step;
    if ({1'b0, tgt} > w_limit) begin
      return w_limit[ACC_ACT_W-1:0];
    end
    return tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_watchdog.sv
// =====================================================================
// Module      : acc_watchdog
// Description : Sensor-freshness watchdog. Counts cycles since the last
//               clear pulse, saturating at SENSOR_TIMEOUT; stale is
//               high while the count sits at the limit.
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

module acc_watchdog #(
  parameter int SENSOR_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic stale
);

  localparam int c_cnt_w = (SENSOR_TIMEOUT > 0) ? $clog2(SENSOR_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(SENSOR_TIMEOUT);

  logic [c_cnt_w-1:0] r_count;

  // Age counter: clear wins, otherwise count up and stick at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != c_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign stale = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/acc_mode_controller.sv
// =====================================================================
// Module      : acc_mode_controller
// Description : Supervisory FSM for the ACC longitudinal pipeline.
//               Selects pipeline or driver commands for the actuators,
//               handles engage, override, cancel and sensor watchdog,
//               and rate-limits throttle rise while ACTIVE.
// Options     : ACC_RESUME_EN - adds resume_req input and set_speed
//               output (resume to last engaged speed).
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

module acc_mode_controller #(
  parameter int SENSOR_TIMEOUT = 1000,
  parameter int OVERRIDE_HOLD  = 200,
  parameter int THR_STEP       = 4,
  parameter int SPEED_MIN      = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        main_sw,
  input  logic        engage_req,
  input  logic        cancel_req,
  input  logic        brake_pedal,
  input  logic [7:0]  accel_pedal,
  input  logic [15:0] vehicle_speed,
  input  logic        sensor_valid,
  input  logic [7:0]  acc_throttle,
  input  logic [7:0]  acc_brake,
`ifdef ACC_RESUME_EN
  input  logic        resume_req,
  output logic [15:0] set_speed,
`endif
  output logic [7:0]  throttle_cmd,
  output logic [7:0]  brake_cmd,
  output logic        acc_active,
  output logic        fault,
  output logic [2:0]  state_out
);

  import acc_pkg::*;

  // Hold counter only needs to reach OVERRIDE_HOLD-1 before the exit fires.
  localparam int c_hold_w = (OVERRIDE_HOLD > 1) ? $clog2(OVERRIDE_HOLD) : 1;
  localparam logic [c_hold_w-1:0]    c_hold_last = c_hold_w'(OVERRIDE_HOLD - 1);
  localparam logic [ACC_SPEED_W-1:0] c_speed_min = ACC_SPEED_W'(SPEED_MIN);
  localparam logic [ACC_ACT_W:0]     c_thr_step  = (ACC_ACT_W + 1)'(THR_STEP);

  acc_state_e           r_state;
  acc_state_e           w_next_state;
  logic [c_hold_w-1:0]  r_hold;
  logic [c_hold_w-1:0]  w_hold_next;
  logic [ACC_ACT_W-1:0] r_throttle;
  logic [ACC_ACT_W-1:0] r_brake;
  logic [ACC_ACT_W-1:0] w_throttle_next;
  logic [ACC_ACT_W-1:0] w_brake_next;
  logic                 r_acc_active;
  logic                 r_fault;
  logic                 w_stale;
  logic                 w_speed_ok;
  logic                 w_pedal_ok;
  logic                 w_engage_ok;
  logic                 w_resume_ok;

  acc_watchdog #(
    .SENSOR_TIMEOUT(SENSOR_TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .reset(reset),
    .clear(sensor_valid),
    .stale(w_stale)
  );

  assign w_speed_ok  = (vehicle_speed >= c_speed_min);
  assign w_pedal_ok  = (accel_pedal <= acc_throttle);
  assign w_engage_ok = engage_req && w_speed_ok && !w_stale && !brake_pedal;

`ifdef ACC_RESUME_EN
  logic [ACC_SPEED_W-1:0] r_set_speed;

  assign w_resume_ok = resume_req && (r_set_speed != '0) && w_speed_ok &&
                       !w_stale && !brake_pedal;

  // Remembered cruise speed: captured on a fresh engage, lost with main_sw.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_set_speed <= '0;
    end else if (!main_sw) begin
      r_set_speed <= '0;
    end else if (r_state == ACC_STANDBY && w_engage_ok) begin
      r_set_speed <= vehicle_speed;
    end
  end

  assign set_speed = r_set_speed;
`else
  assign w_resume_ok = 1'b0;
`endif

  // Next-state selection, lower rules overridden by the higher ones below.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACC_OFF:      w_next_state = ACC_STANDBY;
      ACC_STANDBY:  if (w_engage_ok || w_resume_ok) w_next_state = ACC_ACTIVE;
      ACC_ACTIVE: begin
        if (w_stale)                        w_next_state = ACC_FAULT;
        else if (brake_pedal || cancel_req) w_next_state = ACC_STANDBY;
        else if (!w_pedal_ok)               w_next_state = ACC_OVERRIDE;
      end
      ACC_OVERRIDE: begin
        if (w_stale)                             w_next_state = ACC_FAULT;
        else if (brake_pedal || cancel_req)      w_next_state = ACC_STANDBY;
        else if (w_pedal_ok && r_hold == c_hold_last) w_next_state = ACC_ACTIVE;
      end
      ACC_FAULT:    w_next_state = ACC_FAULT;
      default:      w_next_state = ACC_OFF;
    endcase
    if (!main_sw) begin
      w_next_state = ACC_OFF;
    end
  end

  // Hold count of consecutive released-pedal cycles while staying in OVERRIDE.
  always_comb begin
    w_hold_next = '0;
    if (r_state == ACC_OVERRIDE && w_next_state == ACC_OVERRIDE && w_pedal_ok) begin
      w_hold_next = r_hold + 1'b1;
    end
  end

  // Actuator commands for the state being entered.
  always_comb begin
    w_throttle_next = accel_pedal;
    w_brake_next    = '0;
    if (w_next_state == ACC_ACTIVE) begin
      w_throttle_next = acc_ramp(r_throttle, acc_throttle, c_thr_step);
      w_brake_next    = acc_brake;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ACC_OFF;
      r_hold       <= '0;
      r_throttle   <= '0;
      r_brake      <= '0;
      r_acc_active <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_hold       <= w_hold_next;
      r_throttle   <= w_throttle_next;
      r_brake      <= w_brake_next;
      r_acc_active <= (w_next_state == ACC_ACTIVE) || (w_next_state == ACC_OVERRIDE);
      r_fault      <= (w_next_state == ACC_FAULT);
    end
  end

  assign state_out    = r_state;
  assign throttle_cmd = r_throttle;
  assign brake_cmd    = r_brake;
  assign acc_active   = r_acc_active;
  assign fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_acc_mode_controller.sv
// =====================================================================
// Module      : tb_acc_mode_controller
// Description : Self-checking bench for acc_mode_controller: directed
//               scenarios followed by randomized traffic, every cycle
//               compared against a behavioural model of the rules.
// Options     : ACC_RESUME_EN - also exercises resume_req / set_speed.
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_acc_mode_controller;

  localparam int T     = 60;
  localparam int HOLD  = 25;
  localparam int STEP  = 4;
  localparam int SPMIN = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        main_sw = 1'b0;
  logic        engage_req = 1'b0;
  logic        cancel_req = 1'b0;
  logic        brake_pedal = 1'b0;
  logic [7:0]  accel_pedal = 8'd0;
  logic [15:0] vehicle_speed = 16'd0;
  logic        sensor_valid = 1'b0;
  logic [7:0]  acc_throttle = 8'd0;
  logic [7:0]  acc_brake = 8'd0;
  logic [7:0]  throttle_cmd;
  logic [7:0]  brake_cmd;
  logic        acc_active;
  logic        fault;
  logic [2:0]  state_out;
`ifdef ACC_RESUME_EN
  logic        resume_req = 1'b0;
  logic [15:0] set_speed;
  int          m_set;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sv_mode = 1'b0;

  // Reference model state (plain integers, spec state numbering)
  int m_st, m_thr, m_brk, m_wd, m_run;

  acc_mode_controller #(
    .SENSOR_TIMEOUT(T),
    .OVERRIDE_HOLD (HOLD),
    .THR_STEP      (STEP),
    .SPEED_MIN     (SPMIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .main_sw      (main_sw),
    .engage_req   (engage_req),
    .cancel_req   (cancel_req),
    .brake_pedal  (brake_pedal),
    .accel_pedal  (accel_pedal),
    .vehicle_speed(vehicle_speed),
    .sensor_valid (sensor_valid),
    .acc_throttle (acc_throttle),
    .acc_brake    (acc_brake),
`ifdef ACC_RESUME_EN
    .resume_req   (resume_req),
    .set_speed    (set_speed),
`endif
    .throttle_cmd (throttle_cmd),
    .brake_cmd    (brake_cmd),
    .acc_active   (acc_active),
    .fault        (fault),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply the supervisory rules to the inputs present at this clock edge.
  task automatic model_step();
    bit stale, in_loop, engage_ok;
    int ns;
    if (reset) begin
      m_st = 0; m_thr = 0; m_brk = 0; m_wd = 0; m_run = 0;
`ifdef ACC_RESUME_EN
      m_set = 0;
`endif
      return;
    end
    stale     = (m_wd == T);
    in_loop   = (m_st == 2) || (m_st == 3);
    engage_ok = engage_req && (int'(vehicle_speed) >= SPMIN) && !stale && !brake_pedal;
    ns = m_st;
    if (!main_sw)                                  ns = 0;
    else if (m_st > 4)                             ns = 0;
    else if (in_loop && stale)                     ns = 4;
    else if (in_loop && (brake_pedal || cancel_req)) ns = 1;
    else if (m_st == 2) begin
      if (accel_pedal > acc_throttle) ns = 3;
    end else if (m_st == 3) begin
      m_run = (accel_pedal <= acc_throttle) ? m_run + 1 : 0;
      if (m_run >= HOLD) ns = 2;
    end else if (m_st == 0) begin
      ns = 1;
    end else if (m_st == 1) begin
      if (engage_ok) begin
        ns = 2;
`ifdef ACC_RESUME_EN
        m_set = int'(vehicle_speed);
`endif
      end
`ifdef ACC_RESUME_EN
      else if (resume_req && m_set != 0 && !stale && !brake_pedal &&
               int'(vehicle_speed) >= SPMIN) ns = 2;
`endif
    end
    if (ns != 3) m_run = 0;
`ifdef ACC_RESUME_EN
    if (!main_sw) m_set = 0;
`endif
    if (ns == 2) begin
      m_brk = int'(acc_brake);
      if (int'(acc_throttle) > m_thr)
        m_thr = (m_thr + STEP < int'(acc_throttle)) ? m_thr + STEP : int'(acc_throttle);
      else
        m_thr = int'(acc_throttle);
    end else begin
      m_brk = 0;
      m_thr = int'(accel_pedal);
    end
    m_wd = sensor_valid ? 0 : ((m_wd < T) ? m_wd + 1 : T);
    m_st = ns;
  endtask

  task automatic compare_all();
    chk("state_out",    32'(state_out),    32'(m_st));
    chk("throttle_cmd", 32'(throttle_cmd), 32'(m_thr));
    chk("brake_cmd",    32'(brake_cmd),    32'(m_brk));
    chk("acc_active",   32'(acc_active),   ((m_st == 2) || (m_st == 3)) ? 32'd1 : 32'd0);
    chk("fault",        32'(fault),        (m_st == 4) ? 32'd1 : 32'd0);
`ifdef ACC_RESUME_EN
    chk("set_speed",    32'(set_speed),    32'(m_set));
`endif
  endtask

  // One clock: inputs already set; model at the edge, compare at negedge.
  task automatic tick();
    if (sv_mode) sensor_valid = (cyc % 10 == 0);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic go_active();
    main_sw = 1'b1; brake_pedal = 1'b0; cancel_req = 1'b0;
    vehicle_speed = 16'd50; accel_pedal = 8'd20; acc_throttle = 8'd100; sv_mode = 1'b1;
    for (int i = 0; i < 40 && !(m_st == 1 && m_wd != T); i++) tick();
    engage_req = 1'b1; tick(); engage_req = 1'b0;
    chk("engage_active", 32'(state_out), 32'd2);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_thr",   32'(throttle_cmd), 32'd0);
    reset = 1'b0;

    // 1. Basic engage and throttle ramp 24,28,...,100
    go_active();
    chk("ramp_first", 32'(throttle_cmd), 32'd24);
    for (int k = 2; k <= 22; k++) begin
      tick();
      chk("ramp_step", 32'(throttle_cmd), (20 + 4 * k > 100) ? 32'd100 : 32'(20 + 4 * k));
    end

    // 2. Engage refused below speed or with brake, accepted at SPEED_MIN
    cancel_req = 1'b1; tick(); cancel_req = 1'b0;
    chk("cancel_standby", 32'(state_out), 32'd1);
    vehicle_speed = 16'd29; engage_req = 1'b1; tick(); engage_req = 1'b0;
    chk("slow_refused", 32'(state_out), 32'd1);
    vehicle_speed = 16'd30; brake_pedal = 1'b1; engage_req = 1'b1; tick(); engage_req = 1'b0;
    chk("brake_refused", 32'(state_out), 32'd1);
    brake_pedal = 1'b0; engage_req = 1'b1; tick(); engage_req = 1'b0;
    chk("min_speed_engage", 32'(state_out), 32'd2);

    // 3. Override and return after HOLD clean cycles, restart on violation
    accel_pedal = 8'd150; tick();
    chk("override_enter", 32'(state_out), 32'd3);
    chk("override_thr",   32'(throttle_cmd), 32'd150);
    accel_pedal = 8'd90;
    repeat (HOLD - 1) tick();
    chk("hold_pending", 32'(state_out), 32'd3);
    accel_pedal = 8'd150; tick(); accel_pedal = 8'd90;
    repeat (HOLD - 1) tick();
    chk("hold_restart", 32'(state_out), 32'd3);
    tick();
    chk("hold_return", 32'(state_out), 32'd2);
    chk("hold_ramp",   32'(throttle_cmd), 32'd94);

    // 4. Watchdog fault, sticky until main_sw drops
    acc_brake = 8'd55; accel_pedal = 8'd77; sv_mode = 1'b0; sensor_valid = 1'b0;
    for (int i = 0; i < T + 15 && state_out != 3'd4; i++) tick();
    chk("wd_fault_state", 32'(state_out), 32'd4);
    chk("wd_fault_flag",  32'(fault), 32'd1);
    chk("wd_fault_brake", 32'(brake_cmd), 32'd0);
    chk("wd_fault_thr",   32'(throttle_cmd), 32'd77);
    sensor_valid = 1'b1; tick(); sensor_valid = 1'b0;
    chk("fault_sticky", 32'(state_out), 32'd4);
    main_sw = 1'b0; tick();
    chk("fault_exit", 32'(state_out), 32'd0);

    // 5. Simultaneous events
    go_active();
    sv_mode = 1'b0; sensor_valid = 1'b0;
    for (int i = 0; i < T + 5 && m_wd != T; i++) tick();
    brake_pedal = 1'b1; tick(); brake_pedal = 1'b0;
    chk("stale_beats_brake", 32'(state_out), 32'd4);
    main_sw = 1'b0; tick(); main_sw = 1'b1; tick();
    main_sw = 1'b0; engage_req = 1'b1; tick(); engage_req = 1'b0;
    chk("mainsw_beats_engage", 32'(state_out), 32'd0);
    go_active();
    accel_pedal = 8'd150; cancel_req = 1'b1; tick(); cancel_req = 1'b0; accel_pedal = 8'd20;
    chk("cancel_beats_override", 32'(state_out), 32'd1);

    // 6. Reset mid-ramp
    go_active();
    acc_brake = 8'd200; acc_throttle = 8'd250;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_state", 32'(state_out), 32'd0);
    chk("midreset_thr",   32'(throttle_cmd), 32'd0);
    chk("midreset_brake", 32'(brake_cmd), 32'd0);
`ifdef ACC_RESUME_EN
    chk("midreset_setspd", 32'(set_speed), 32'd0);
    tick();
    resume_req = 1'b1; tick(); resume_req = 1'b0;
    chk("resume_blocked", 32'(state_out), 32'd1);
`endif

    // Randomized traffic against the model
    sv_mode = 1'b0;
    for (int seg = 0; seg < 16; seg++) begin
      int vprob;
      vprob = (seg % 4 == 3) ? 0 : 4;
      for (int i = 0; i < 200; i++) begin
        sensor_valid = (vprob != 0) && ($urandom_range(vprob - 1) == 0);
        main_sw      = ($urandom_range(99) != 0);
        reset        = ($urandom_range(599) == 0);
        engage_req   = ($urandom_range(7) == 0);
        cancel_req   = ($urandom_range(59) == 0);
        if (brake_pedal) begin
          if ($urandom_range(4) == 0) brake_pedal = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          brake_pedal = 1'b1;
        end
        if ($urandom_range(29) == 0) accel_pedal   = 8'($urandom_range(255));
        if ($urandom_range(29) == 0) acc_throttle  = 8'($urandom_range(255));
        if ($urandom_range(9) == 0)  vehicle_speed = 16'($urandom_range(60, 25));
        acc_brake = 8'($urandom_range(255));
`ifdef ACC_RESUME_EN
        resume_req = ($urandom_range(9) == 0);
`endif
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_mode_controller.md
Name: acc_mode_controller

Overview:
- Supervisory FSM that sequences the adaptive-cruise longitudinal pipeline.
- Decides when the pipeline's throttle/brake commands reach the actuators and when the driver's pedal passes through instead.
- Enforces engage conditions, driver override, cancel, and a sensor-freshness watchdog.
- Rate-limits throttle application; sits between the ACC control pipeline outputs and the actuator drivers.

Parameters:
- SENSOR_TIMEOUT, 1000: cycles without sensor_valid before sensor data is stale.
- OVERRIDE_HOLD, 200: consecutive cycles of pedal release needed to leave OVERRIDE.
- THR_STEP, 4: max throttle_cmd increase per cycle in ACTIVE.
- SPEED_MIN, 30: minimum vehicle_speed to engage (same units as vehicle_speed).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- main_sw  in  1  ACC master switch (level)
- engage_req  in  1  driver set/engage request (single-cycle pulse)
- cancel_req  in  1  driver cancel (pulse)
- brake_pedal  in  1  driver brake pedal pressed (level)
- accel_pedal  in  8  driver accelerator position
- vehicle_speed  in  16  unsigned own speed
- sensor_valid  in  1  pulse per fresh radar/speed sample
- acc_throttle  in  8  throttle demand from ACC pipeline
- acc_brake  in  8  brake demand from ACC pipeline
- throttle_cmd  out  8  registered throttle to actuator
- brake_cmd  out  8  registered brake to actuator
- acc_active  out  1  high in ACTIVE or OVERRIDE
- fault  out  1  high in FAULT
- state_out  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and takes precedence over all inputs. On reset: state=OFF, throttle_cmd=0, brake_cmd=0, acc_active=0, fault=0, state_out=0, watchdog=0, hold counter=0.
- State encodings: OFF=0, STANDBY=1, ACTIVE=2, OVERRIDE=3, FAULT=4. Codes 5–7 are illegal and go to OFF next cycle.
- Watchdog:
  - Counter is cleared on sensor_valid; otherwise it increments and saturates at SENSOR_TIMEOUT.
  - stale = (count == SENSOR_TIMEOUT).
  - sensor_valid in the same cycle as stale clears the counter; stale deasserts next cycle.
- Transitions are evaluated every cycle, highest priority first:
  1. main_sw=0 -> OFF, from any state including FAULT.
  2. stale in ACTIVE or OVERRIDE -> FAULT.
  3. brake_pedal or cancel_req in ACTIVE or OVERRIDE -> STANDBY.
  4. ACTIVE -> OVERRIDE when accel_pedal > acc_throttle.
  5. OVERRIDE -> ACTIVE when accel_pedal <= acc_throttle for OVERRIDE_HOLD consecutive cycles. The hold counter clears on any violation and on OVERRIDE entry.
  6. OFF -> STANDBY when main_sw=1.
  7. STANDBY -> ACTIVE when engage_req && vehicle_speed >= SPEED_MIN && !stale && !brake_pedal. If any condition fails, the pulse is ignored and not remembered.
- FAULT exits only via main_sw=0.
- Outputs are registered from the next state, so state_out, acc_active and fault change in the same cycle as the transition edge. Per next state:
  - OFF, STANDBY: throttle_cmd=accel_pedal, brake_cmd=0.
  - FAULT: throttle_cmd=accel_pedal, brake_cmd=0, fault=1.
  - OVERRIDE: throttle_cmd=accel_pedal, brake_cmd=0.
  - ACTIVE, brake_cmd: equals acc_brake.
  - ACTIVE, throttle_cmd: ramps from its current value. Increase uses 9-bit math: if acc_throttle > throttle_cmd+THR_STEP then throttle_cmd+THR_STEP, else acc_throttle. Decrease applies immediately.
- Throttle_cmd is never forced to 0 on entering ACTIVE; the ramp starts from the value driven in the prior state.

Optional Feature:
- Macro: ACC_RESUME_EN.
- With the macro:
  - Adds input resume_req (pulse) and output set_speed[15:0], reset 0.
  - A successful engage captures vehicle_speed into set_speed.
  - resume_req in STANDBY with set_speed!=0, !stale, !brake_pedal and vehicle_speed>=SPEED_MIN -> ACTIVE without recapture.
  - main_sw=0 clears set_speed.
- Without the macro: neither port exists; resume is impossible.

Decomposition:
- Package acc_pkg: state encodings (ACC_OFF..ACC_FAULT), state width 3, actuator width 8, speed width 16.
- One sub-module, acc_watchdog: counter with clear/saturate and a stale output, parameterised by SENSOR_TIMEOUT; reused for the future lead-distance sensor.

Test Plan:
1. Basic engage. Stimulus: reset, main_sw=1, sensor_valid every 10 cycles, speed=50, engage_req. Required response: STANDBY then ACTIVE (state_out=2). With acc_throttle=100 from throttle_cmd=20, throttle_cmd steps 24,28,...,100 and holds.
2. Engage refused. Stimulus: engage_req with speed=29, or with brake_pedal=1. Required response: stays STANDBY; the same request at speed=30 with brake released engages.
3. Override and return. Stimulus: in ACTIVE, accel_pedal=150 > acc_throttle=100. Required response: OVERRIDE and throttle_cmd=150. After pedal drops to 90, ACTIVE returns exactly OVERRIDE_HOLD cycles later; a single violating cycle restarts the count.
4. Watchdog fault. Stimulus: in ACTIVE, stop sensor_valid. Required response: FAULT after SENSOR_TIMEOUT cycles, with fault=1, brake_cmd=0 and throttle_cmd=accel_pedal. Only main_sw=0 returns to OFF; sensor_valid alone has no effect.
5. Simultaneous events. Stimulus: stale and brake_pedal in the same cycle. Required response: FAULT. main_sw=0 together with engage_req gives OFF. cancel_req together with accel override gives STANDBY.
6. Reset mid-operation. Stimulus: assert reset during ACTIVE ramp with acc_brake=200. Required response: next edge gives state_out=0, throttle_cmd=0, brake_cmd=0. With ACC_RESUME_EN, set_speed=0 and resume_req has no effect until a new engage.
